// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared register-file transfer package: default widths, controller state encoding
// and command legality helper.
package reg_xfer_ctrl_pkg;

    localparam int RXC_DATA_WIDTH = 32;
    localparam int RXC_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_FIN  = 2'd3
    } xfer_state_e;

    // A transfer may touch each register at most once, and must move at least one word.
    function automatic logic count_is_legal(input int unsigned count, input int unsigned n_regs);
        return (count != 0) && (count <= n_regs);
    endfunction

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Bundle of command, load stream, dump stream, register-file and status signals
// between the transfer controller (master) and its surroundings (slave).
interface reg_xfer_ctrl_if
    import reg_xfer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = RXC_DATA_WIDTH,
    parameter int ADDR_WIDTH = RXC_ADDR_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_dir;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [ADDR_WIDTH:0]   cmd_count;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [ADDR_WIDTH-1:0] rf_raddr;
    logic [DATA_WIDTH-1:0] rf_rdata;

    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  cmd_valid, cmd_dir, cmd_base, cmd_count,
        output cmd_ready,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output rf_wen, rf_waddr, rf_wdata, rf_raddr,
        input  rf_rdata,
        output busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_dir, cmd_base, cmd_count,
        input  cmd_ready,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  rf_wen, rf_waddr, rf_wdata, rf_raddr,
        output rf_rdata,
        input  busy, done, err
    );

endinterface

// File: rtl/reg_xfer_ctrl.sv
// Register-file block transfer controller: loads a stream into consecutive registers
// or dumps consecutive registers into a stream through a one-entry output buffer.
module reg_xfer_ctrl
    import reg_xfer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = RXC_DATA_WIDTH,
    parameter int ADDR_WIDTH = RXC_ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    reg_xfer_ctrl_if.master bus
);

    localparam int unsigned         N_REGS   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    xfer_state_e           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
    logic [ADDR_WIDTH:0]   remaining_reg, remaining_next;
    logic                  err_reg, err_next;
    logic                  out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                  out_last_reg, out_last_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            err_reg       <= err_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        err_next       = err_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    ptr_next       = bus.cmd_base;
                    remaining_next = bus.cmd_count;
                    if (!count_is_legal(32'(bus.cmd_count), N_REGS)) begin
                        err_next   = 1'b1;
                        state_next = ST_FIN;
                    end else begin
                        err_next   = 1'b0;
                        state_next = bus.cmd_dir ? ST_DUMP : ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (bus.in_valid) begin
                    ptr_next       = ptr_reg + 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == CNT_ONE) begin
                        state_next = ST_FIN;
                    end
                end
            end

            ST_DUMP: begin
                if (out_valid_reg && bus.out_ready && out_last_reg) begin
                    state_next = ST_FIN;
                end
                // Refill whenever the buffer is empty or being drained this cycle.
                if ((!out_valid_reg || bus.out_ready) && (remaining_reg != CNT_ZERO)) begin
                    out_data_next  = bus.rf_rdata;
                    out_valid_next = 1'b1;
                    out_last_next  = (remaining_reg == CNT_ONE);
                    ptr_next       = ptr_reg + 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                end else if (out_valid_reg && bus.out_ready) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                end
            end

            ST_FIN: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Write strobe and load handshake are masked by rst so no write escapes in the reset cycle.
    assign bus.cmd_ready = (state_reg == ST_IDLE);
    assign bus.in_ready  = (state_reg == ST_LOAD) && !rst;
    assign bus.rf_wen    = (state_reg == ST_LOAD) && bus.in_valid && !rst;
    assign bus.rf_waddr  = ptr_reg;
    assign bus.rf_wdata  = bus.in_data;
    assign bus.rf_raddr  = ptr_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.done      = (state_reg == ST_FIN);
    assign bus.err       = (state_reg == ST_FIN) && err_reg;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Scoreboard bench for reg_xfer_ctrl: directed commands push expected writes, beats and
// done events; a negedge monitor pops and compares them as the controller produces them.
module tb_reg_xfer_ctrl;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          gap;
    } wr_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          gap;
    } beat_t;

    typedef struct {
        logic err;
        bit   chk_gap;
    } done_t;

    logic clk;
    logic rst;

    reg_xfer_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_xfer_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom [32];
    assign bus.rf_rdata = rom[bus.rf_raddr];

    wr_t   exp_wr   [$];
    beat_t exp_beat [$];
    done_t exp_done [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_xfer_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: every output event is matched against the head of its queue.
    always @(negedge clk) begin : monitor
        wr_t   w;
        beat_t b;
        done_t d;
        cyc++;
        if (bus.rf_wen === 1'b1) begin
            if (exp_wr.size() == 0) begin
                flag("unexpected_write");
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", 64'(bus.rf_waddr), 64'(w.addr));
                check("wr_data", 64'(bus.rf_wdata), 64'(w.data));
                check("in_ready_on_write", 64'(bus.in_ready), 64'd1);
                if (w.gap != 0) check("wr_gap", 64'(cyc - last_xfer_cyc), 64'(w.gap));
                $display("write  addr=%0d data=%0h cycle=%0d", bus.rf_waddr, bus.rf_wdata, cyc);
            end
            last_xfer_cyc = cyc;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_beat.size() == 0) begin
                flag("unexpected_beat");
            end else begin
                b = exp_beat.pop_front();
                check("beat_data", 64'(bus.out_data), 64'(b.data));
                check("beat_last", 64'(bus.out_last), 64'(b.last));
                if (b.gap != 0) check("beat_gap", 64'(cyc - last_xfer_cyc), 64'(b.gap));
                $display("beat   data=%0h last=%0b cycle=%0d", bus.out_data, bus.out_last, cyc);
            end
            last_xfer_cyc = cyc;
        end
        if (bus.done === 1'b1) begin
            if (exp_done.size() == 0) begin
                flag("unexpected_done");
            end else begin
                d = exp_done.pop_front();
                check("done_err", 64'(bus.err), 64'(d.err));
                if (d.chk_gap) check("done_latency", 64'(cyc - last_xfer_cyc), 64'd1);
                $display("done   err=%0b cycle=%0d", bus.err, cyc);
            end
        end else if (bus.err === 1'b1) begin
            flag("err_without_done");
        end
    end

    task automatic push_wr(input logic [4:0] a, input logic [31:0] dt, input int gap);
        wr_t w;
        w.addr = a; w.data = dt; w.gap = gap;
        exp_wr.push_back(w);
    endtask

    task automatic push_beat(input logic [31:0] dt, input logic last, input int gap);
        beat_t b;
        b.data = dt; b.last = last; b.gap = gap;
        exp_beat.push_back(b);
    endtask

    task automatic push_done(input logic e, input bit g);
        done_t d;
        d.err = e; d.chk_gap = g;
        exp_done.push_back(d);
    endtask

    task automatic send_cmd(input logic dir, input logic [4:0] base, input logic [5:0] count);
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_base  = base;
        bus.cmd_count = count;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Drives out_ready from a repeating pattern until the expected done is seen.
    task automatic wait_done(input string name, input logic [7:0] pat, input int plen);
        int k = 0;
        while (exp_done.size() != 0 && k < 200) begin
            bus.out_ready = pat[k % plen];
            @(posedge clk); #1;
            k++;
        end
        bus.out_ready = 1'b1;
        if (exp_done.size() != 0) begin
            flag({name, "_timeout"});
            exp_done.delete();
        end
        check({name, "_writes_drained"}, 64'(exp_wr.size()), 64'd0);
        check({name, "_beats_drained"}, 64'(exp_beat.size()), 64'd0);
        check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
        exp_wr.delete();
        exp_beat.delete();
    endtask

    task automatic run_load(input string name, input logic [4:0] base, input logic [5:0] count,
                            input logic [31:0] dat [5], input logic [7:0] pat, input int plen);
        int idx = 0;
        int k = 0;
        logic v;
        send_cmd(1'b0, base, count);
        while (idx < int'(count) && k < 100) begin
            v = pat[k % plen];
            bus.in_valid = v;
            bus.in_data  = v ? dat[idx] : (32'hBAD0_0000 | 32'(k));
            @(posedge clk); #1;
            if (v) idx++;
            k++;
        end
        bus.in_valid = 1'b0;
        wait_done(name, 8'h01, 1);
    endtask

    logic [31:0] dat [5];

    initial begin : stim
        for (int n = 0; n < 32; n++) rom[n] = 32'(n) * 32'h100;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_count = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_done",      64'(bus.done),      64'd0);
        check("rst_err",       64'(bus.err),       64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_rf_wen",    64'(bus.rf_wen),    64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load base 3, count 3, back-to-back data.
        dat = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
        push_wr(5'd3, 32'h11, 0);
        push_wr(5'd4, 32'h22, 1);
        push_wr(5'd5, 32'h33, 1);
        push_done(1'b0, 1'b1);
        run_load("load_3x3", 5'd3, 6'd3, dat, 8'h01, 1);

        // Dump base 30, count 4, wrapping through address 0.
        push_beat(32'h1E00, 1'b0, 0);
        push_beat(32'h1F00, 1'b0, 1);
        push_beat(32'h0000, 1'b0, 1);
        push_beat(32'h0100, 1'b1, 1);
        push_done(1'b0, 1'b1);
        send_cmd(1'b1, 5'd30, 6'd4);
        wait_done("dump_wrap", 8'h01, 1);

        // Dump base 5, count 3, out_ready pattern 1,0,0 repeating.
        push_beat(32'h0500, 1'b0, 0);
        push_beat(32'h0600, 1'b0, 0);
        push_beat(32'h0700, 1'b1, 0);
        push_done(1'b0, 1'b1);
        send_cmd(1'b1, 5'd5, 6'd3);
        wait_done("dump_stall", 8'b0000_0001, 3);

        // Illegal counts with in_valid and out_ready both held high.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        push_done(1'b1, 1'b0);
        send_cmd(1'b0, 5'd7, 6'd0);
        wait_done("illegal_0", 8'h01, 1);
        push_done(1'b1, 1'b0);
        send_cmd(1'b1, 5'd7, 6'd33);
        wait_done("illegal_33", 8'h01, 1);
        bus.in_valid = 1'b0;

        // Reset after 2 of 5 load words; the reset cycle keeps in_valid high.
        push_wr(5'd10, 32'hA1, 0);
        push_wr(5'd11, 32'hA2, 1);
        send_cmd(1'b0, 5'd10, 6'd5);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hA1;
        @(posedge clk); #1;
        bus.in_data  = 32'hA2;
        @(posedge clk); #1;
        bus.in_data  = 32'hA3;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("midrst_busy",      64'(bus.busy),      64'd0);
        check("midrst_done",      64'(bus.done),      64'd0);
        check("midrst_in_ready",  64'(bus.in_ready),  64'd0);
        check("midrst_writes",    64'(exp_wr.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        dat = '{32'h5A, 32'h0, 32'h0, 32'h0, 32'h0};
        push_wr(5'd0, 32'h5A, 0);
        push_done(1'b0, 1'b1);
        run_load("load_after_rst", 5'd0, 6'd1, dat, 8'h01, 1);

        // Load count 3 with in_valid gaps 1,0,1,0,1.
        dat = '{32'hC1, 32'hC2, 32'hC3, 32'h0, 32'h0};
        push_wr(5'd20, 32'hC1, 0);
        push_wr(5'd21, 32'hC2, 2);
        push_wr(5'd22, 32'hC3, 2);
        push_done(1'b0, 1'b1);
        run_load("load_gaps", 5'd20, 6'd3, dat, 8'b0001_0101, 5);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_xfer_ctrl.md
REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the register address width (2^ADDR_WIDTH = 32 registers).
REQ-003 SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_dir (in, 1; 0=load, 1=dump), cmd_base (in, ADDR_WIDTH), cmd_count (in, ADDR_WIDTH+1): the command handshake.
REQ-006 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_data (in, DATA_WIDTH): the load data stream.
REQ-007 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_data (out, DATA_WIDTH), out_last (out, 1): the dump data stream.
REQ-008 SHALL have ports rf_wen (out, 1), rf_waddr (out, ADDR_WIDTH), rf_wdata (out, DATA_WIDTH), rf_raddr (out, ADDR_WIDTH), rf_rdata (in, DATA_WIDTH, combinational read of rf_raddr): the register-file master port.
REQ-009 SHALL have ports busy (out, 1), done (out, 1, single-cycle pulse), err (out, 1, single-cycle pulse with done).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, DUMP, FIN.
REQ-011 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&&cmd_ready.
REQ-012 SHALL, on accepting a command, load ptr<=cmd_base, remaining<=cmd_count, and go to LOAD (dir=0) or DUMP (dir=1).
REQ-013 SHALL treat cmd_count==0 or cmd_count>32 as illegal: the command is accepted, no rf or stream activity occurs, FSM goes directly to FIN, and err pulses with done.
REQ-014 SHALL increment ptr modulo 2^ADDR_WIDTH on each transferred word (base 30, count 4 -> addresses 30,31,0,1).
REQ-015 SHALL, in LOAD, hold in_ready=1 and drive rf_wen=in_valid, rf_waddr=ptr, rf_wdata=in_data combinationally, for zero-latency writes.
REQ-016 SHALL issue writes to address 0 like any other address; write suppression for register 0 is the register file's responsibility.
REQ-017 SHALL, in LOAD, go to FIN in the cycle after the write for which remaining==1.
REQ-018 SHALL, in DUMP, drive rf_raddr=ptr and keep a one-entry registered output buffer: when the buffer is empty or out_valid&&out_ready, and words remain to be read, capture out_data<=rf_rdata and out_valid<=1, and set out_last=1 iff it is the final word.
REQ-019 SHALL sustain one dump word per cycle while out_ready=1; out_data and out_last SHALL be stable while out_valid&&!out_ready.
REQ-020 SHALL, in DUMP, go to FIN in the cycle after the beat with out_last=1 is accepted, with out_valid=0 from that point.
REQ-021 SHALL, in FIN, pulse done (and err if applicable) for exactly one cycle, then return to IDLE.
REQ-022 SHALL drive busy=1 in every state except IDLE.
REQ-023 SHALL drive rf_wen=0 outside LOAD, and in_ready=0 outside LOAD.

Reset
REQ-024 SHALL, on rst, return to IDLE, cmd_ready=1, and out_valid=out_last=rf_wen=in_ready=busy=done=err=0, with ptr, remaining and out_data cleared to 0.
REQ-025 SHALL, on rst during LOAD or DUMP, abandon the transfer without a done pulse; no rf_wen may be asserted in the reset cycle.

Structure
REQ-026 SHALL take DATA_WIDTH/ADDR_WIDTH defaults and the FSM state encoding from the shared register-file package.
REQ-027 SHALL be a single module with no sub-modules; the output buffer is inline.

Verification
REQ-028 Load base 3, count 3, data 0x11,0x22,0x33 with in_valid held -> rf_wen on 3 consecutive cycles to addresses 3,4,5; done pulses 1 cycle later; err=0.
REQ-029 Dump base 30, count 4, out_ready=1, with the regfile model holding reg[n]=n*0x100 -> out_data 0x1E00,0x1F00,0x0000,0x0100 on consecutive cycles; out_last only on the 4th beat.
REQ-030 Dump count 3 with out_ready toggling 1,0,0,1,... -> no beat lost or duplicated; out_data stable during stalls.
REQ-031 Command with cmd_count=0, then cmd_count=33 -> no rf_wen and no out_valid; done&&err pulse for each.
REQ-032 Assert rst mid-LOAD after 2 of 5 words -> next cycle IDLE, cmd_ready=1, no done; a new load of base 0, count 1 then completes normally.
REQ-033 Load with in_valid gaps (1,0,1,0,1), count 3 -> exactly 3 writes, to consecutive addresses, only on in_valid cycles.
